// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode/funct constants, FSM state codes, ALU-op and access-size types
package cpu_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   // alt selects SUB/SRA; callers must only raise it where funct7 is meaningful
   function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
      return f3 == F3_ADD  ? (alt ? ALU_SUB : ALU_ADD) :
             f3 == F3_SLL  ? ALU_SLL  :
             f3 == F3_SLT  ? ALU_SLT  :
             f3 == F3_SLTU ? ALU_SLTU :
             f3 == F3_XOR  ? ALU_XOR  :
             f3 == F3_SR   ? (alt ? ALU_SRA : ALU_SRL) :
             f3 == F3_OR   ? ALU_OR   : ALU_AND;
   endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational RV32 integer ALU with branch-compare flags
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_t     op,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic        ltu
);
   assign eq  = a == b;
   assign lt  = $signed(a) < $signed(b);
   assign ltu = a < b;

   always_comb begin
      result = op == ALU_ADD  ? a + b :
               op == ALU_SUB  ? a - b :
               op == ALU_SLL  ? a << b[4:0] :
               op == ALU_SLT  ? {31'd0, lt} :
               op == ALU_SLTU ? {31'd0, ltu} :
               op == ALU_XOR  ? a ^ b :
               op == ALU_SRL  ? a >> b[4:0] :
               op == ALU_SRA  ? $unsigned($signed(a) >>> b[4:0]) :
               op == ALU_OR   ? a | b : a & b;
   end
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle RV32I/RV32E core (FETCH/DECODE/EXEC/MEM) on sync BRAM ports.
// Define CPU_TRAP_EN to halt on faults; otherwise faulting instructions degrade to NOPs.
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        aclk,
   input  logic        aresetn,
   output logic [31:0] addr_inst,
   output logic [31:0] data_out_inst,
   input  logic [31:0] data_in_inst,
   output logic        en_inst,
   output logic [3:0]  we_inst,
   output logic [31:0] addr_data,
   output logic [31:0] data_out_data,
   input  logic [31:0] data_in_data,
   output logic        en_data,
   output logic [3:0]  we_data,
   output logic        retire,
   output logic        trap
);
   localparam int RW = $clog2(NUM_REGS);

   if ((NUM_REGS != 32) && (NUM_REGS != 16)) begin : g_bad_num_regs
      $error("cpu_multicycle: NUM_REGS must be 16 or 32");
   end

   logic [2:0]  state, state_nx;
   logic [31:0] pc, inst, pc_plus4, pc_next;
   logic [31:0] rf [NUM_REGS];
   logic [6:0]  opc, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [31:0] rv1, rv2, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_imm, is_op, is_fence;
   logic        uses_rd, uses_rs1, uses_rs2, legal, bad_reg, ok_inst;
   logic [31:0] alu_a, alu_b, alu_res, jump_tgt, ea, lane_word, ld_val, wr_data;
   alu_op_t     alu_op;
   logic        eq, lt, ltu, br_take, redirect;
   size_t       sz;
   logic [1:0]  lane;
   logic [3:0]  mask;
   logic        trap_now, exec_go, do_ld, do_st, wr_en;

   assign opc = inst[6:0];
   assign rd  = inst[11:7];
   assign f3  = inst[14:12];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign f7  = inst[31:25];

   // Out-of-range indices only occur on RV32E and are rejected as illegal below
   assign rv1 = (rs1 == 5'd0 || (NUM_REGS == 16 && rs1[4])) ? '0 : rf[rs1[RW-1:0]];
   assign rv2 = (rs2 == 5'd0 || (NUM_REGS == 16 && rs2[4])) ? '0 : rf[rs2[RW-1:0]];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'd0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   assign is_lui    = opc == OP_LUI;
   assign is_auipc  = opc == OP_AUIPC;
   assign is_jal    = opc == OP_JAL;
   assign is_jalr   = opc == OP_JALR;
   assign is_branch = opc == OP_BRANCH;
   assign is_load   = opc == OP_LOAD;
   assign is_store  = opc == OP_STORE;
   assign is_imm    = opc == OP_IMM;
   assign is_op     = opc == OP_OP;
   assign is_fence  = opc == OP_FENCE;

   assign uses_rd  = is_lui | is_auipc | is_jal | is_jalr | is_load | is_op | is_imm;
   assign uses_rs1 = is_jalr | is_branch | is_load | is_store | is_op | is_imm;
   assign uses_rs2 = is_branch | is_store | is_op;

   assign legal = is_lui | is_auipc | is_jal | is_fence
                | (is_jalr && f3 == 3'd0)
                | (is_branch && f3[2:1] != 2'b01)
                | (is_load && f3[1:0] != 2'b11 && f3 != 3'b110)
                | (is_store && f3 < 3'd3)
                | (is_op && (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))))
                | (is_imm && (f3 == F3_SLL ? f7 == F7_BASE :
                              f3 == F3_SR  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1));
   assign bad_reg = (NUM_REGS == 16) && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]));
   assign ok_inst = legal && !bad_reg;

   assign alu_a  = is_lui ? '0 : is_auipc ? pc : rv1;
   assign alu_b  = (is_op || is_branch) ? rv2 : (is_lui || is_auipc) ? imm_u : imm_i;
   assign alu_op = (is_op || is_imm) ? alu_decode(f3, inst[30] && (is_op || f3 == F3_SR)) : ALU_ADD;

   cpu_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_res),
      .eq     (eq),
      .lt     (lt),
      .ltu    (ltu)
   );

   assign br_take  = is_branch && ((f3[2] ? (f3[1] ? ltu : lt) : eq) ^ f3[0]);
   assign redirect = is_jal | is_jalr | br_take;
   assign jump_tgt = is_jalr ? ((rv1 + imm_i) & ~32'd1) : pc + (is_jal ? imm_j : imm_b);
   assign pc_plus4 = pc + 32'd4;
   assign pc_next  = (ok_inst && redirect) ? (jump_tgt & ~32'd3) : pc_plus4;

   assign ea   = rv1 + (is_store ? imm_s : imm_i);
   assign sz   = f3[1] ? SZ_W : (f3[0] ? SZ_H : SZ_B);
   // Lane ignores the low address bits that a misaligned access would otherwise use
   assign lane = sz == SZ_W ? 2'b00 : sz == SZ_H ? {ea[1], 1'b0} : ea[1:0];
   assign mask = sz == SZ_B ? 4'b0001 : sz == SZ_H ? 4'b0011 : 4'b1111;

`ifdef CPU_TRAP_EN
   logic mem_mis, tgt_mis;
   assign mem_mis  = (is_load || is_store) && (sz == SZ_H ? ea[0] : sz == SZ_W ? |ea[1:0] : 1'b0);
   assign tgt_mis  = redirect && jump_tgt[1];
   assign trap_now = state == S_EXEC && (!ok_inst || mem_mis || tgt_mis);
   assign trap     = state == S_HALT;
`else
   assign trap_now = 1'b0;
   assign trap     = 1'b0;
`endif

   assign exec_go = state == S_EXEC && !trap_now;
   assign do_ld   = exec_go && ok_inst && is_load;
   assign do_st   = exec_go && ok_inst && is_store;

   assign addr_inst     = pc;
   assign data_out_inst = '0;
   assign we_inst       = '0;
   assign en_inst       = state == S_FETCH;
   assign en_data       = do_ld | do_st;
   assign we_data       = do_st ? mask << lane : 4'd0;
   assign addr_data     = en_data ? {ea[31:2], 2'b00} : '0;
   assign data_out_data = !do_st ? '0 : sz == SZ_B ? {4{rv2[7:0]}} : sz == SZ_H ? {2{rv2[15:0]}} : rv2;
   assign retire        = (exec_go && !do_ld) || state == S_MEM;

   assign lane_word = data_in_data >> {lane, 3'b000};
   assign ld_val    = sz == SZ_W ? data_in_data :
                      sz == SZ_H ? {{16{~f3[2] & lane_word[15]}}, lane_word[15:0]} :
                                   {{24{~f3[2] & lane_word[7]}}, lane_word[7:0]};
   assign wr_en   = (exec_go && ok_inst && uses_rd && !is_load) || state == S_MEM;
   assign wr_data = state == S_MEM ? ld_val : (is_jal || is_jalr) ? pc_plus4 : alu_res;

   always_comb begin
      state_nx = state == S_RESET  ? S_FETCH :
                 state == S_FETCH  ? S_DECODE :
                 state == S_DECODE ? S_EXEC :
                 state == S_EXEC   ? (trap_now ? S_HALT : do_ld ? S_MEM : S_FETCH) :
                 state == S_HALT   ? S_HALT : S_FETCH;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_RESET;
         pc    <= RESET_PC;
         inst  <= '0;
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) inst <= data_in_inst;
         if (state == S_MEM) pc <= pc_plus4;
         else if (exec_go && !do_ld) pc <= pc_next;
         if (wr_en && rd != 5'd0) rf[rd[RW-1:0]] <= wr_data;
      end
   end
endmodule
